// File: rtl/jtcontra_gfx_line_reader.sv
// Two-bank scanline buffer reader: displays the bank not being rendered.
// Define JTCONTRA_LBUF_ERASE_EN to clear each pixel right after it is read.
module jtcontra_gfx_line_reader #(
  parameter int          DW      = 9,
  parameter int          AW      = 9,
  parameter logic [8:0]  HOFFSET = 9'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [8:0]    hdump,
  input  logic          line,
  input  logic          scr_we,
  input  logic [AW:0]   line_addr,
  input  logic [DW-1:0] line_din,
  output logic [DW-1:0] pxl,
  output logic          opaque,
  output logic          col_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    ERASE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_mem [0:(2**(AW+1))-1];
  logic          r_rd_bank;
  logic [AW:0]   r_addr;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_pxl;
  logic          r_opaque;
  logic          r_col;

  logic          w_latch;
  logic          w_blank;
  logic          w_load;
  logic          w_we_b;
  logic [AW-1:0] w_pix;

  assign w_pix   = AW'(hdump) - AW'(HOFFSET);
  assign pxl     = r_pxl;
  assign opaque  = r_opaque;
  assign col_err = r_col;

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_blank = 1'b0;
    w_load  = 1'b0;
    w_we_b  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (pxl_cen) begin
          if (LHBL) begin
            w_latch = 1'b1;
            w_next  = RD;
          end else begin
            w_blank = 1'b1;
          end
        end
      end
      RD: begin
        w_next = ERASE;
      end
      ERASE: begin
        w_load = 1'b1;
        w_next = IDLE;
`ifdef JTCONTRA_LBUF_ERASE_EN
        w_we_b = ~rst;
`else
        w_we_b = 1'b0;
`endif
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    r_rd_bank <= ~line;
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_addr <= {r_rd_bank, w_pix};
    end
    if (r_state == RD) begin
      r_q <= r_mem[r_addr];
    end
  end

  // Port A is written last so it wins a same-address clash with the erase
  always_ff @(posedge clk) begin
    if (w_we_b) begin
      r_mem[r_addr] <= '0;
    end
    if (scr_we) begin
      r_mem[line_addr] <= line_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pxl    <= '0;
      r_opaque <= 1'b0;
    end else if (w_load) begin
      r_pxl    <= r_q;
      r_opaque <= |r_q[3:0];
    end else if (w_blank) begin
      r_pxl    <= '0;
      r_opaque <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= 1'b0;
    end else if (scr_we && (line_addr[AW] == r_rd_bank)
                 && (r_state != IDLE)) begin
      r_col <= 1'b1;
    end
  end

endmodule
